// File: rtl/cmsdk_fpga_sram_arb_pkg.sv
// Shared encodings for the two-port SRAM arbiter: port IDs, lock owner states, lock idle limit.
// Optional lock feature is enabled with CMSDK_FPGA_SRAM_ARB_LOCK_EN.
package cmsdk_fpga_sram_arb_pkg;

  typedef enum logic {
    PORT_P0 = 1'b0,
    PORT_P1 = 1'b1
  } port_id_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam int LOCK_IDLE_LIMIT = 16;
  localparam int LOCK_CNT_W      = $clog2(LOCK_IDLE_LIMIT);

  function automatic logic is_read(input logic [3:0] wren);
    return wren == 4'b0000;
  endfunction

endpackage

// File: rtl/cmsdk_fpga_sram_arb_rr.sv
// Two-way round-robin pick with last_grant register; grant is combinational, zero while reset.
module cmsdk_fpga_sram_arb_rr
  import cmsdk_fpga_sram_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  port_id_e r_last;
  logic     w_pick_p1;

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    w_pick_p1 = i_req1 && (!i_req0 || (r_last == PORT_P0));
    o_gnt1    = !i_rst && w_pick_p1;
    o_gnt0    = !i_rst && i_req0 && !w_pick_p1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= PORT_P1;
    end else if (o_gnt0) begin
      r_last <= PORT_P0;
    end else if (o_gnt1) begin
      r_last <= PORT_P1;
    end
  end

endmodule

// File: rtl/cmsdk_fpga_sram_arb.sv
// Two-port single-cycle SRAM arbiter: same-cycle grant and SRAM drive, read data one cycle later.
// Defining CMSDK_FPGA_SRAM_ARB_LOCK_EN adds P0_LOCK/P1_LOCK ownership with a bounded idle hold.
module cmsdk_fpga_sram_arb
  import cmsdk_fpga_sram_arb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          CLK,
  input  logic          RST,
`ifdef CMSDK_FPGA_SRAM_ARB_LOCK_EN
  input  logic          P0_LOCK,
  input  logic          P1_LOCK,
`endif
  input  logic          P0_REQ,
  input  logic [AW-1:0] P0_ADDR,
  input  logic [31:0]   P0_WDATA,
  input  logic [3:0]    P0_WREN,
  output logic          P0_GNT,
  output logic          P0_RVALID,
  output logic [31:0]   P0_RDATA,
  input  logic          P1_REQ,
  input  logic [AW-1:0] P1_ADDR,
  input  logic [31:0]   P1_WDATA,
  input  logic [3:0]    P1_WREN,
  output logic          P1_GNT,
  output logic          P1_RVALID,
  output logic [31:0]   P1_RDATA,
  output logic [AW-1:0] SRAM_ADDR,
  output logic [31:0]   SRAM_WDATA,
  output logic [3:0]    SRAM_WREN,
  output logic          SRAM_CS,
  input  logic [31:0]   SRAM_RDATA
);

  logic w_elig0, w_elig1;
  logic w_gnt0, w_gnt1;
  logic r_rvld0, r_rvld1;

`ifdef CMSDK_FPGA_SRAM_ARB_LOCK_EN
  owner_e                r_owner, w_owner_nxt;
  logic [LOCK_CNT_W-1:0] r_idle_cnt, w_idle_cnt_nxt;
  logic                  w_own_req, w_own_lock;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_owner    <= OWN_NONE;
      r_idle_cnt <= '0;
    end else begin
      r_owner    <= w_owner_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  // Ownership ends on an unlocked grant to the owner, an unlocked idle owner, or the idle limit.
  always_comb begin
    w_own_req      = (r_owner == OWN_P0) ? P0_REQ  : P1_REQ;
    w_own_lock     = (r_owner == OWN_P0) ? P0_LOCK : P1_LOCK;
    w_owner_nxt    = r_owner;
    w_idle_cnt_nxt = r_idle_cnt;
    if (w_gnt0 || w_gnt1) begin
      w_idle_cnt_nxt = '0;
      if (w_gnt0 && P0_LOCK) begin
        w_owner_nxt = OWN_P0;
      end else if (w_gnt1 && P1_LOCK) begin
        w_owner_nxt = OWN_P1;
      end else if ((w_gnt0 && r_owner == OWN_P0) || (w_gnt1 && r_owner == OWN_P1)) begin
        w_owner_nxt = OWN_NONE;
      end
    end else if (r_owner != OWN_NONE && !w_own_req) begin
      if (!w_own_lock || r_idle_cnt == LOCK_CNT_W'(LOCK_IDLE_LIMIT - 1)) begin
        w_owner_nxt    = OWN_NONE;
        w_idle_cnt_nxt = '0;
      end else begin
        w_idle_cnt_nxt = r_idle_cnt + LOCK_CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_elig0 = P0_REQ && (r_owner != OWN_P1);
    w_elig1 = P1_REQ && (r_owner != OWN_P0);
  end
`else
  always_comb begin
    w_elig0 = P0_REQ;
    w_elig1 = P1_REQ;
  end
`endif

  cmsdk_fpga_sram_arb_rr u_rr (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_req0 (w_elig0),
    .i_req1 (w_elig1),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  always_comb begin
    P0_GNT     = w_gnt0;
    P1_GNT     = w_gnt1;
    SRAM_CS    = w_gnt0 || w_gnt1;
    SRAM_ADDR  = '0;
    SRAM_WDATA = '0;
    SRAM_WREN  = '0;
    if (w_gnt0) begin
      SRAM_ADDR  = P0_ADDR;
      SRAM_WDATA = P0_WDATA;
      SRAM_WREN  = P0_WREN;
    end else if (w_gnt1) begin
      SRAM_ADDR  = P1_ADDR;
      SRAM_WDATA = P1_WDATA;
      SRAM_WREN  = P1_WREN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rvld0 <= 1'b0;
      r_rvld1 <= 1'b0;
    end else begin
      r_rvld0 <= w_gnt0 && is_read(P0_WREN);
      r_rvld1 <= w_gnt1 && is_read(P1_WREN);
    end
  end

  // Reset landing on the return cycle kills that read's response.
  always_comb begin
    P0_RVALID = r_rvld0 && !RST;
    P1_RVALID = r_rvld1 && !RST;
    P0_RDATA  = P0_RVALID ? SRAM_RDATA : '0;
    P1_RDATA  = P1_RVALID ? SRAM_RDATA : '0;
  end

endmodule
